stopwatch_timer_core: RTL and testbench



---
 rtl/stopwatch_timer_core.sv | 161 ++++++++++++++++
 tb/tb_stopwatch_timer_core.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_timer_core.sv
// Stopwatch/countdown timer core: prescaled base tick, up/down min:sec count,
// run/pause/done control, lap freeze and wrap/saturate overflow policy.
module stopwatch_timer_core #(
   parameter int TICKS_PER_SEC = 100,
   parameter int MIN_W         = 7,
   parameter int MIN_MAX       = 99,
   parameter int WRAP          = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tick,
   input  logic             start_stop,
   input  logic             clear,
   input  logic             lap,
   input  logic             count_down,
   input  logic [MIN_W-1:0] load_min,
   input  logic [5:0]       load_sec,
   output logic [MIN_W-1:0] disp_min,
   output logic [5:0]       disp_sec,
   output logic             running,
   output logic             lap_hold,
   output logic             done,
   output logic             overflow
);
   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0]    PLAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [MIN_W-1:0] MMAX  = MIN_W'(MIN_MAX);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t           state, state_n;
   logic [MIN_W-1:0] min_q, min_n, fmin_q, fmin_n;
   logic [5:0]       sec_q, sec_n, fsec_q, fsec_n;
   logic [PW-1:0]    presc_q, presc_n;
   logic             mode_q, mode_n;
   logic             lap_hold_n, done_n, ovf_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         min_q    <= '0;
         sec_q    <= '0;
         fmin_q   <= '0;
         fsec_q   <= '0;
         presc_q  <= '0;
         mode_q   <= 1'b0;
         lap_hold <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         running  <= 1'b0;
      end else begin
         state    <= state_n;
         min_q    <= min_n;
         sec_q    <= sec_n;
         fmin_q   <= fmin_n;
         fsec_q   <= fsec_n;
         presc_q  <= presc_n;
         mode_q   <= mode_n;
         lap_hold <= lap_hold_n;
         done     <= done_n;
         overflow <= ovf_n;
         running  <= (state_n == RUN);
      end
   end

   always_comb begin
      state_n    = state;
      min_n      = min_q;
      sec_n      = sec_q;
      fmin_n     = fmin_q;
      fsec_n     = fsec_q;
      presc_n    = presc_q;
      mode_n     = mode_q;
      lap_hold_n = lap_hold;
      done_n     = 1'b0;
      ovf_n      = overflow;

      if (clear) begin
         state_n    = IDLE;
         min_n      = '0;
         sec_n      = '0;
         presc_n    = '0;
         lap_hold_n = 1'b0;
         ovf_n      = 1'b0;
      end else if (start_stop) begin
         case (state)
            IDLE: begin
               mode_n  = count_down;
               presc_n = '0;
               if (count_down) begin
                  min_n = (load_min > MMAX) ? MMAX : load_min;
                  sec_n = (load_sec > 6'd59) ? 6'd59 : load_sec;
                  if (min_n == '0 && sec_n == '0) begin
                     state_n = DONE;
                     done_n  = 1'b1;
                  end else begin
                     state_n = RUN;
                  end
               end else begin
                  min_n   = '0;
                  sec_n   = '0;
                  state_n = RUN;
               end
            end
            RUN:     state_n = PAUSE;
            PAUSE:   state_n = RUN;
            default: ;
         endcase
      end else if (state == RUN || state == PAUSE) begin
         // lap captures the pre-step count; a same-cycle step only moves live regs
         if (lap) begin
            if (lap_hold) begin
               lap_hold_n = 1'b0;
            end else begin
               fmin_n     = min_q;
               fsec_n     = sec_q;
               lap_hold_n = 1'b1;
            end
         end
         if (state == RUN && tick) begin
            if (presc_q == PLAST) begin
               presc_n = '0;
               if (!mode_q) begin
                  if (sec_q < 6'd59) begin
                     sec_n = sec_q + 6'd1;
                  end else if (min_q < MMAX) begin
                     sec_n = '0;
                     min_n = min_q + MIN_W'(1);
                  end else if (WRAP != 0) begin
                     sec_n = '0;
                     min_n = '0;
                     ovf_n = 1'b1;
                  end else begin
                     state_n    = DONE;
                     done_n     = 1'b1;
                     lap_hold_n = 1'b0;
                  end
               end else begin
                  if (sec_q != '0) begin
                     sec_n = sec_q - 6'd1;
                  end else begin
                     sec_n = 6'd59;
                     min_n = min_q - MIN_W'(1);
                  end
                  if (min_n == '0 && sec_n == '0) begin
                     state_n    = DONE;
                     done_n     = 1'b1;
                     lap_hold_n = 1'b0;
                  end
               end
            end else begin
               presc_n = presc_q + PW'(1);
            end
         end
      end
   end

   assign disp_min = lap_hold ? fmin_q : min_q;
   assign disp_sec = lap_hold ? fsec_q : sec_q;

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Directed bench: three cores (MIN_MAX 99/wrap, 1/wrap, 1/saturate) share stimulus.
module tb_stopwatch_timer_core;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0, count_down = 1'b0;
   logic [6:0] load_min = '0;
   logic [5:0] load_sec = '0;

   logic [6:0] dmin0;
   logic [0:0] dmin1, dmin2;
   logic [5:0] dsec0, dsec1, dsec2;
   logic       run0, run1, run2, lh0, lh1, lh2, dn0, dn1, dn2, ov0, ov1, ov2;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   stopwatch_timer_core #(.TICKS_PER_SEC(4), .MIN_W(7), .MIN_MAX(99), .WRAP(1)) u0 (
      .clk(clk), .reset_n(reset_n), .tick(tick), .start_stop(start_stop), .clear(clear),
      .lap(lap), .count_down(count_down), .load_min(load_min), .load_sec(load_sec),
      .disp_min(dmin0), .disp_sec(dsec0), .running(run0), .lap_hold(lh0), .done(dn0),
      .overflow(ov0));

   stopwatch_timer_core #(.TICKS_PER_SEC(4), .MIN_W(1), .MIN_MAX(1), .WRAP(1)) u1 (
      .clk(clk), .reset_n(reset_n), .tick(tick), .start_stop(start_stop), .clear(clear),
      .lap(lap), .count_down(count_down), .load_min(load_min[0:0]), .load_sec(load_sec),
      .disp_min(dmin1), .disp_sec(dsec1), .running(run1), .lap_hold(lh1), .done(dn1),
      .overflow(ov1));

   stopwatch_timer_core #(.TICKS_PER_SEC(4), .MIN_W(1), .MIN_MAX(1), .WRAP(0)) u2 (
      .clk(clk), .reset_n(reset_n), .tick(tick), .start_stop(start_stop), .clear(clear),
      .lap(lap), .count_down(count_down), .load_min(load_min[0:0]), .load_sec(load_sec),
      .disp_min(dmin2), .disp_sec(dsec2), .running(run2), .lap_hold(lh2), .done(dn2),
      .overflow(ov2));

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // one-cycle strobe set up at negedge; returns 1 time unit after the capturing edge
   task automatic pulse(input logic t, input logic ss, input logic cl, input logic lp);
      @(negedge clk);
      tick = t; start_stop = ss; clear = cl; lap = lp;
      @(posedge clk);
      #1;
      tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) pulse(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic int d0();
      return int'(dmin0) * 100 + int'(dsec0);
   endfunction
   function automatic int d1();
      return int'(dmin1) * 100 + int'(dsec1);
   endfunction
   function automatic int d2();
      return int'(dmin2) * 100 + int'(dsec2);
   endfunction

   initial begin
      #12;
      chk("rst_disp", d0(), 0);
      chk("rst_flags", {run0, lh0, dn0, ov0}, 0);
      reset_n = 1'b1;

      // up mode, minute rollover, overflow wrap vs saturate
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      chk("up_running", run0, 1);
      ticks(236);
      chk("up_0_59", d0(), 59);
      ticks(4);
      chk("up_1_00", d0(), 100);
      ticks(236);
      chk("up_1_59", d0(), 159);
      chk("sat_1_59_pre", d2(), 159);
      ticks(4);
      chk("up_2_00", d0(), 200);
      chk("wrap_0_00", d1(), 0);
      chk("wrap_ovf", ov1, 1);
      chk("wrap_running", run1, 1);
      chk("sat_hold", d2(), 159);
      chk("sat_done", dn2, 1);
      chk("sat_running", run2, 0);
      idle_cycle();
      chk("sat_done_once", dn2, 0);
      ticks(4);
      chk("wrap_0_01", d1(), 1);
      chk("wrap_ovf_sticky", ov1, 1);
      chk("sat_still", d2(), 159);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      chk("clr_ovf", ov1, 0);
      chk("clr_disp", d0(), 0);
      chk("clr_running", run0, 0);

      // pause / resume keeps prescaler phase
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(6);
      chk("pr_0_01", d0(), 1);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      chk("pr_paused", run0, 0);
      ticks(20);
      chk("pr_frozen", d0(), 1);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      chk("pr_resumed", run0, 1);
      ticks(2);
      chk("pr_0_02", d0(), 2);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);

      // down mode from 0:02
      count_down = 1'b1; load_min = 7'd0; load_sec = 6'd2;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      count_down = 1'b0;
      chk("dn_load", d0(), 2);
      ticks(4);
      chk("dn_0_01", d0(), 1);
      ticks(3);
      chk("dn_not_yet", d0(), 1);
      ticks(1);
      chk("dn_0_00", d0(), 0);
      chk("dn_done", dn0, 1);
      chk("dn_running", run0, 0);
      idle_cycle();
      chk("dn_done_once", dn0, 0);
      ticks(4);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      chk("dn_hold", d0(), 0);
      chk("dn_stays_done", {run0, dn0}, 0);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);

      // zero load goes straight to DONE; clamping of load values
      count_down = 1'b1; load_min = 7'd0; load_sec = 6'd0;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      chk("zl_done", dn0, 1);
      chk("zl_running", run0, 0);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      load_min = 7'd0; load_sec = 6'd63;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      chk("clamp_sec", d0(), 59);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      load_min = 7'd127; load_sec = 6'd63;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      chk("clamp_min", d0(), 9959);
      chk("clamp_min_u1", d1(), 159);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      count_down = 1'b0; load_min = '0; load_sec = '0;

      // lap freeze
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(20);
      chk("lap_live_0_05", d0(), 5);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      chk("lap_hold_on", lh0, 1);
      ticks(12);
      chk("lap_frozen", d0(), 5);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      chk("lap_hold_off", lh0, 0);
      chk("lap_live_0_08", d0(), 8);
      ticks(7);
      pulse(1'b1, 1'b0, 1'b0, 1'b1);
      chk("lap_pre_step", d0(), 9);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      chk("lap_after", d0(), 10);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);

      // priority and async reset
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(4);
      chk("pri_0_01", d0(), 1);
      pulse(1'b0, 1'b1, 1'b1, 1'b0);
      chk("pri_clear_disp", d0(), 0);
      chk("pri_clear_run", run0, 0);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      chk("idle_lap_ignored", lh0, 0);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(8);
      chk("ar_0_02", d0(), 2);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_disp", d0(), 0);
      chk("ar_running", run0, 0);
      #5 reset_n = 1'b1;
      idle_cycle();
      chk("ar_idle", run0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
